// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is never entered on purpose; the controller treats it like IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// Single-bit full adder, purely combinational; the serial controller reuses it once per bit.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop;

  assign prop = a ^ b;
  assign s    = prop ^ cin;
  assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder cell, LSB first, one bit per clock.
// Operands are latched on an accepted start; results stay stable until the next DONE.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             cell_s, cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_final;

  full_adder_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign sum_final = {cell_s, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // IDLE, DONE and the unused encoding all accept a new start
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
      default: state_nxt = start ? ST_RUN : ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath: load on accepted start, shift one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (state != ST_RUN) begin
      if (start) begin
        a_sr   <= a;
        b_sr   <= b;
        c      <= carryin;
        cnt    <= '0;
        sum_sr <= '0;
      end
    end else begin
      sum_sr <= sum_final;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      c      <= cell_cout;
      cnt    <= cnt + 1'b1;
      // Result registers load on the MSB cycle so they are valid throughout DONE
      if (last_bit) begin
        sum      <= sum_final;
        carryout <= cell_cout;
        overflow <= c ^ cell_cout;
      end
    end
  end

endmodule
